hilo_div_sequencer: RTL and testbench
=====================================

Name: hilo_div_sequencer

Overview:
Sequencer that sits between the CPU datapath and the 32-cycle iterative unsigned divider. It does three things:
- Accepts a divide request: signed or unsigned operands, dividend and divisor.
- Converts signed operands to magnitudes, launches the divider through its start/ready handshake and waits for completion.
- Applies sign correction and writes quotient to LO and remainder to HI. Divide-by-zero is trapped without launching the divider.

Parameters:
WIDTH, 32, operand/result width; divider contract assumes WIDTH cycles per divide

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
op_valid  in  1  request strobe; sampled only in IDLE
op_signed  in  1  1 = two's-complement divide, 0 = unsigned
op_a  in  WIDTH  dividend
op_b  in  WIDTH  divisor
busy  out  1  high while a request is in flight
done  out  1  one-cycle pulse when hi/lo are updated
div_by_zero  out  1  set when the last request had op_b==0; cleared on next accepted request
hi  out  WIDTH  remainder register
lo  out  WIDTH  quotient register
dv_q  out  WIDTH  dividend magnitude to divider
dv_m  out  WIDTH  divisor magnitude to divider
dv_start  out  1  divider start request
dv_quotient  in  WIDTH  divider quotient, valid when dv_ready=1 after completion
dv_remainder  in  WIDTH  divider remainder
dv_ready  in  1  divider idle/complete; the divider accepts start on an edge where dv_ready=1, and drops dv_ready after that edge

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy, done, div_by_zero, dv_start=0; hi, lo, dv_q, dv_m=0.
- States: IDLE, LAUNCH, WAIT_DONE.

IDLE (busy=0, dv_start=0):
- On an edge with op_valid=1:
  - Compute qneg = op_signed & (op_a[MSB]^op_b[MSB]) and rneg = op_signed & op_a[MSB].
  - Latch dv_q = |op_a| (if signed, else op_a) and dv_m = |op_b| (if signed, else op_b).
  - Clear div_by_zero.
- If op_b==0:
  - Do not launch the divider.
  - Same edge: hi=op_a, lo={WIDTH{1}}, div_by_zero=1, done=1 for the following cycle.
  - Stay in IDLE.
- Otherwise: go to LAUNCH, busy=1.

LAUNCH (dv_start=1, dv_q/dv_m held stable):
- Advance to WAIT_DONE only on an edge where dv_ready=1; the divider accepts start on that same edge.
- If dv_ready=0 (divider still busy, e.g. after a reset mid-operation), hold dv_start indefinitely.

WAIT_DONE (dv_start=0):
- On the first edge with dv_ready=1:
  - lo = qneg ? -dv_quotient : dv_quotient
  - hi = rneg ? -dv_remainder : dv_remainder
  - done=1 for one cycle, busy=0, go to IDLE.

Latency and handshake:
- Nonzero divisor, divider idle: the accept edge is E0. dv_start is accepted at E1. dv_ready returns after E33. hi/lo are written at E34. done is high during the cycle after E34.
- busy is high from after E0 through E34 and is never high together with done.

Boundary conditions:
- op_valid outside IDLE is ignored; there is no queue.
- Signed -2^(WIDTH-1) / -1: magnitude divide gives 0x80000000 r 0, with qneg=0 and no negation. Result: lo=0x80000000, hi=0 (wraps, no flag).
- Negation is two's complement modulo 2^WIDTH. Magnitude of -2^(WIDTH-1) is 0x80000000.
- Remainder sign follows the dividend; quotient truncates toward zero.
- hi/lo hold their values between writes.
- Reset mid-operation aborts silently: no done, hi/lo=0.

Test Plan:
- Unsigned op_a=100, op_b=3 -> lo=33, hi=1, div_by_zero=0, done exactly 34 edges after accept, dv_start high for 1 cycle.
- Signed op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); signed 7/-2 -> lo=0xFFFFFFFD, hi=1.
- op_a=5, op_b=0 -> done 1 cycle later, lo=0xFFFFFFFF, hi=5, div_by_zero=1, dv_start never asserted; next valid request clears div_by_zero.
- Signed op_a=0x80000000, op_b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- op_valid pulsed during WAIT_DONE -> ignored, hi/lo from first op only. Then:
  - Assert reset mid-WAIT_DONE -> all outputs 0.
  - Issue 55/10 with the divider model holding dv_ready=0 for 5 more cycles -> dv_start held until dv_ready=1, then lo=5, hi=5.

Source files
------------

// File: rtl/hilo_div_sequencer.sv
// Divide sequencer between the CPU datapath and a WIDTH-cycle iterative unsigned divider.
// Handles sign conversion, the divider start/ready handshake, and the HI/LO writeback.
module hilo_div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] dv_q,
  output logic [WIDTH-1:0] dv_m,
  output logic             dv_start,
  input  logic [WIDTH-1:0] dv_quotient,
  input  logic [WIDTH-1:0] dv_remainder,
  input  logic             dv_ready
);

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitDone
  } state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             start_q, start_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] dvq_q, dvq_d;
  logic [WIDTH-1:0] dvm_q, dvm_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  // The most negative value maps onto itself, which is the correct unsigned magnitude.
  assign a_neg = op_signed & op_a[WIDTH-1];
  assign b_neg = op_signed & op_b[WIDTH-1];
  assign mag_a = a_neg ? -op_a : op_a;
  assign mag_b = b_neg ? -op_b : op_b;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    start_d = start_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvq_d   = dvq_q;
    dvm_d   = dvm_q;

    case (state_q)
      StIdle: begin
        if (op_valid) begin
          qneg_d = op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          rneg_d = a_neg;
          dvq_d  = mag_a;
          dvm_d  = mag_b;
          dbz_d  = 1'b0;
          if (op_b == '0) begin
            // Trap without touching the divider.
            hi_d   = op_a;
            lo_d   = '1;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = StLaunch;
            busy_d  = 1'b1;
            start_d = 1'b1;
          end
        end
      end

      StLaunch: begin
        // Divider latches start on this same edge and drops ready afterwards.
        if (dv_ready) begin
          state_d = StWaitDone;
          start_d = 1'b0;
        end
      end

      StWaitDone: begin
        if (dv_ready) begin
          lo_d    = qneg_q ? -dv_quotient : dv_quotient;
          hi_d    = rneg_q ? -dv_remainder : dv_remainder;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      start_q <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvq_q   <= '0;
      dvm_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      start_q <= start_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvq_q   <= dvq_d;
      dvm_q   <= dvm_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign dv_start    = start_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dv_q        = dvq_q;
  assign dv_m        = dvm_q;

endmodule

// File: tb/tb_hilo_div_sequencer.sv
// Self-checking bench for hilo_div_sequencer with a behavioural 32-cycle divider model
// and an arithmetic reference for signed/unsigned divide results.
module tb_hilo_div_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         op_valid = 1'b0;
  logic         op_signed = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy, done, div_by_zero, dv_start, dv_ready;
  logic [W-1:0] hi, lo, dv_q, dv_m, dv_quotient, dv_remainder;

  int total = 0;
  int bad = 0;

  hilo_div_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op_signed   (op_signed),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo),
    .dv_q        (dv_q),
    .dv_m        (dv_m),
    .dv_start    (dv_start),
    .dv_quotient (dv_quotient),
    .dv_remainder(dv_remainder),
    .dv_ready    (dv_ready)
  );

  always #5 clk = ~clk;

  // Divider model: not reset by the sequencer's reset, takes W edges after accepting start.
  int           busy_cnt = 0;
  int           wait_cnt = 0;
  int           accept_delay = 0;
  logic [W-1:0] mq = '0;
  logic [W-1:0] mr = '0;

  assign dv_ready     = (busy_cnt == 0) && !(dv_start && (wait_cnt < accept_delay));
  assign dv_quotient  = mq;
  assign dv_remainder = mr;

  always @(posedge clk) begin
    if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end else if (dv_start) begin
      if (wait_cnt < accept_delay) begin
        wait_cnt <= wait_cnt + 1;
      end else begin
        wait_cnt <= 0;
        busy_cnt <= W;
        mq       <= dv_q / dv_m;
        mr       <= dv_q % dv_m;
      end
    end
  end

  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
    dz = 1'b0;
    if (b == 0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issues one request and measures it; lat is edges from accept to done visible (-1 = timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit inject, output int lat, output int starts, output bit busy_ok);
    @(negedge clk);
    op_a      = a;
    op_b      = b;
    op_signed = s;
    op_valid  = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    lat      = -1;
    starts   = int'(dv_start);
    busy_ok  = !(busy && done);
    if (done) begin
      lat = 0;
    end else begin
      for (int k = 1; k <= 300; k++) begin
        if (inject && k == 10) begin
          op_a      = 32'd1000;
          op_b      = 32'd7;
          op_signed = 1'b0;
          op_valid  = 1'b1;
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        if (busy && done) busy_ok = 1'b0;
        if (!busy && !done) busy_ok = 1'b0;
        if (done) begin
          lat = k;
          break;
        end
        starts += int'(dv_start);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, div_by_zero, dv_start} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000", {busy, done, div_by_zero, dv_start});
    end
    total++;
    if ({hi, lo, dv_q, dv_m} !== '0) begin
      bad++;
      $display("FAIL reset_regs: got hi=%h lo=%h q=%h m=%h want all 0", hi, lo, dv_q, dv_m);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_unsigned;
    int lat, starts;
    bit bok;
    run_op(32'd100, 32'd3, 1'b0, 1'b0, lat, starts, bok);
    total++;
    if (lat !== 34) begin bad++; $display("FAIL unsigned_latency: got %0d want 34", lat); end
    total++;
    if (starts !== 1) begin bad++; $display("FAIL unsigned_start_cycles: got %0d want 1", starts); end
    total++;
    if (lo !== 32'd33 || hi !== 32'd1 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL unsigned_result: got lo=%0d hi=%0d dbz=%b want 33 1 0", lo, hi, div_by_zero);
    end
    total++;
    if (!bok) begin bad++; $display("FAIL unsigned_busy: got overlap/gap want clean busy"); end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || lo !== 32'd33 || hi !== 32'd1) begin
      bad++;
      $display("FAIL hold_after_done: got done=%b lo=%0d hi=%0d want 0 33 1", done, lo, hi);
    end
  endtask

  task automatic test_signed;
    int lat, starts;
    bit bok;
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, lat, starts, bok);
    total++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL signed_m7_2: got lo=%h hi=%h want fffffffd ffffffff", lo, hi);
    end
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, lat, starts, bok);
    total++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'd1 || lat !== 34) begin
      bad++;
      $display("FAIL signed_7_m2: got lo=%h hi=%h lat=%0d want fffffffd 1 34", lo, hi, lat);
    end
  endtask

  task automatic test_div_zero;
    int lat, starts;
    bit bok;
    bit seen_start;
    run_op(32'd5, 32'd0, 1'b0, 1'b0, lat, starts, bok);
    total++;
    if (lat !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL dbz_done: got lat=%0d busy=%b want 0 0", lat, busy);
    end
    total++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'd5 || div_by_zero !== 1'b1) begin
      bad++;
      $display("FAIL dbz_result: got lo=%h hi=%h dbz=%b want ffffffff 5 1", lo, hi, div_by_zero);
    end
    seen_start = (starts != 0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (dv_start) seen_start = 1'b1;
    end
    total++;
    if (seen_start || done !== 1'b0) begin
      bad++;
      $display("FAIL dbz_no_start: got start_seen=%b done=%b want 0 0", seen_start, done);
    end
    run_op(32'd9, 32'd4, 1'b0, 1'b0, lat, starts, bok);
    total++;
    if (div_by_zero !== 1'b0 || lo !== 32'd2 || hi !== 32'd1) begin
      bad++;
      $display("FAIL dbz_clear: got dbz=%b lo=%0d hi=%0d want 0 2 1", div_by_zero, lo, hi);
    end
  endtask

  task automatic test_min_neg1;
    int lat, starts;
    bit bok;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, lat, starts, bok);
    total++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL min_div_m1: got lo=%h hi=%h dbz=%b want 80000000 0 0", lo, hi, div_by_zero);
    end
  endtask

  task automatic test_ignored_valid;
    int lat, starts;
    bit bok;
    run_op(32'd200, 32'd9, 1'b0, 1'b1, lat, starts, bok);
    total++;
    if (lo !== 32'd22 || hi !== 32'd2 || lat !== 34) begin
      bad++;
      $display("FAIL ignored_valid: got lo=%0d hi=%0d lat=%0d want 22 2 34", lo, hi, lat);
    end
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || lo !== 32'd22 || hi !== 32'd2) begin
      bad++;
      $display("FAIL no_queue: got busy=%b lo=%0d hi=%0d want 0 22 2", busy, lo, hi);
    end
  endtask

  task automatic test_reset_mid;
    bit saw_done;
    bit ready_back;
    @(negedge clk);
    op_a      = 32'd77;
    op_b      = 32'd5;
    op_signed = 1'b0;
    op_valid  = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, div_by_zero, dv_start, hi, lo, dv_q, dv_m} !== '0) begin
      bad++;
      $display("FAIL reset_mid: got busy=%b done=%b start=%b hi=%h lo=%h want all 0",
               busy, done, dv_start, hi, lo);
    end
    @(negedge clk);
    reset    = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done || busy || hi != 0 || lo != 0) saw_done = 1'b1;
    end
    total++;
    if (saw_done) begin bad++; $display("FAIL reset_abort: got activity after reset want none"); end
    ready_back = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (dv_ready) begin
        ready_back = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (!ready_back) begin bad++; $display("FAIL divider_idle: got ready=0 want 1"); end
  endtask

  task automatic test_stall;
    int lat, starts;
    bit bok;
    accept_delay = 5;
    run_op(32'd55, 32'd10, 1'b0, 1'b0, lat, starts, bok);
    accept_delay = 0;
    total++;
    if (starts !== 6 || lat !== 39) begin
      bad++;
      $display("FAIL stall_handshake: got starts=%0d lat=%0d want 6 39", starts, lat);
    end
    total++;
    if (lo !== 32'd5 || hi !== 32'd5 || !bok) begin
      bad++;
      $display("FAIL stall_result: got lo=%0d hi=%0d busy_ok=%b want 5 5 1", lo, hi, bok);
    end
  endtask

  task automatic test_random;
    int lat, starts;
    bit bok;
    logic [W-1:0] a, b, eq, er;
    logic s, edz;
    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = 0;
        1: b = $urandom_range(1, 17);
        2: b = -$urandom_range(1, 17);
        default: b = $urandom;
      endcase
      if (n == 7) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
        s = 1'b1;
      end
      ref_div(a, b, s, eq, er, edz);
      run_op(a, b, s, 1'b0, lat, starts, bok);
      total++;
      if (lo !== eq || hi !== er || div_by_zero !== edz) begin
        bad++;
        $display("FAIL random_%0d: a=%h b=%h s=%b got lo=%h hi=%h dbz=%b want %h %h %b",
                 n, a, b, s, lo, hi, div_by_zero, eq, er, edz);
      end
      total++;
      if (lat !== (edz ? 0 : 34) || starts !== (edz ? 0 : 1) || !bok) begin
        bad++;
        $display("FAIL random_timing_%0d: got lat=%0d starts=%0d busy_ok=%b want %0d %0d 1",
                 n, lat, starts, bok, edz ? 0 : 34, edz ? 0 : 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_min_neg1();
    test_ignored_valid();
    test_reset_mid();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
